// File: rtl/ad9833_cfg_ctrl.sv
// ad9833_cfg_ctrl: programs an AD9833 DDS through an external 16-bit serializer.
// The controller sends five words on one cfg_start: reset/B28, FREQ0 LSBs,
// FREQ0 MSBs, PHASE0 and the final control word that selects the waveform.
// Each word is presented with ad9833_wr_en held high until the serializer
// reports completion, plus two trailing cycles. A fixed idle gap follows each
// word. A watchdog aborts the sequence if the serializer never finishes a word.
module ad9833_cfg_ctrl #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [27:0] freq_word,
  input  logic [11:0] phase_word,
  input  logic [1:0]  wave_sel,
  input  logic        ad9833_wr_finish,
  output logic [15:0] ad9833_data,
  output logic        ad9833_wr_en,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err
);

  // One shared counter times SEND (watchdog), HOLD and GAP, so it is sized
  // for the longest of them.
  localparam int CNT_MAX     = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam int HOLD_CYCLES = 2;

  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_HOLD,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [27:0]       freq_q, freq_d;
  logic [11:0]       phase_q, phase_d;
  logic [1:0]        wave_q, wave_d;
  logic [15:0]       data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Word table: the control words keep B28 set so FREQ0 is written as two
  // 14-bit halves, and the last word releases RESET with the chosen waveform.
  function automatic logic [15:0] cfg_word(input logic [2:0]  idx,
                                           input logic [27:0] freq,
                                           input logic [11:0] phase,
                                           input logic [1:0]  wave);
    logic [15:0] w;
    case (idx)
      3'd0:    w = 16'h2100;
      3'd1:    w = {2'b01, freq[13:0]};
      3'd2:    w = {2'b01, freq[27:14]};
      3'd3:    w = {4'hC, phase};
      default: begin
        case (wave)
          2'd0:    w = 16'h2000;
          2'd1:    w = 16'h2002;
          2'd2:    w = 16'h2028;
          default: w = 16'h2020;
        endcase
      end
    endcase
    return w;
  endfunction

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    freq_d  = freq_q;
    phase_d = phase_q;
    wave_d  = wave_q;
    data_d  = data_q;
    wr_en_d = wr_en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          freq_d  = freq_word;
          phase_d = phase_word;
          wave_d  = wave_sel;
          idx_d   = 3'd0;
          cnt_d   = '0;
          data_d  = cfg_word(3'd0, freq_word, phase_word, wave_sel);
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        // A finish arriving on the watchdog's final cycle still counts.
        if (ad9833_wr_finish) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (cnt_q == TMO_LAST) begin
          wr_en_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        // Keep the enable up so the serializer can finish its last SCLK edge.
        if (cnt_q == HOLD_LAST) begin
          wr_en_d = 1'b0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 3'd1;
            data_d  = cfg_word(idx_q + 3'd1, freq_q, phase_q, wave_q);
            wr_en_d = 1'b1;
            state_d = S_SEND;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE, S_ERR: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        wr_en_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the serializer enable at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the reset branch is asynchronous so ad9833_wr_en falls the moment
    // rst_n does, not at the next clock edge.
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      freq_q  <= '0;
      phase_q <= '0;
      wave_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the values
      // from before this edge regardless of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      phase_q <= phase_d;
      wave_q  <= wave_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ad9833_data  = data_q;
  assign ad9833_wr_en = wr_en_q;
  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_ad9833_cfg_ctrl.sv
// Testbench for ad9833_cfg_ctrl: a behavioural serializer answers each word,
// a monitor records words, enable windows, gap lengths and status pulses,
// and directed scenario tasks compare against hand-computed values.
module tb_ad9833_cfg_ctrl;

  localparam int GAP     = 4;
  localparam int TMO     = 64;
  localparam int SER_LEN = 18;
  localparam int BOUND   = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [27:0] freq_word;
  logic [11:0] phase_word;
  logic [1:0]  wave_sel;
  logic        ad9833_wr_finish;
  logic [15:0] ad9833_data;
  logic        ad9833_wr_en;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;

  int errors = 0;
  int checks = 0;

  // Stimulus-side controls of the serializer model
  bit ser_en    = 1'b1;
  bit spur_mode = 1'b0;

  // Monitor records
  logic [15:0] words[$];
  int          gaps[$];
  int          win_cnt   = 0;
  int          done_cnt  = 0;
  int          err_cnt   = 0;
  int          both_cnt  = 0;
  int          unstable  = 0;
  int          cyc       = 0;

  ad9833_cfg_ctrl #(
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_start       (cfg_start),
    .freq_word       (freq_word),
    .phase_word      (phase_word),
    .wave_sel        (wave_sel),
    .ad9833_wr_finish(ad9833_wr_finish),
    .ad9833_data     (ad9833_data),
    .ad9833_wr_en    (ad9833_wr_en),
    .cfg_busy        (cfg_busy),
    .cfg_done        (cfg_done),
    .cfg_err         (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Serializer model: finish pulse SER_LEN cycles into each enable window;
  // in spur_mode it also fires finish whenever the enable is low mid-sequence.
  initial begin
    int ser_cnt;
    ser_cnt = 0;
    ad9833_wr_finish = 1'b0;
    forever begin
      @(negedge clk);
      ad9833_wr_finish = 1'b0;
      if (ad9833_wr_en) begin
        ser_cnt++;
        if (ser_en && ser_cnt == SER_LEN) ad9833_wr_finish = 1'b1;
      end else begin
        ser_cnt = 0;
        if (spur_mode && cfg_busy) ad9833_wr_finish = 1'b1;
      end
    end
  end

  // Monitor: words at each enable rise, low-gap lengths inside a sequence,
  // data stability within a window, and status pulse counts.
  initial begin
    logic        prev_en;
    logic [15:0] prev_data;
    bit          in_gap;
    int          low_run;
    prev_en = 1'b0;
    prev_data = '0;
    in_gap = 1'b0;
    low_run = 0;
    forever begin
      @(negedge clk);
      if (ad9833_wr_en && !prev_en) begin
        words.push_back(ad9833_data);
        win_cnt++;
        if (in_gap) gaps.push_back(low_run);
        in_gap = 1'b0;
      end else if (!ad9833_wr_en && prev_en) begin
        in_gap = 1'b1;
        low_run = 1;
      end else if (!ad9833_wr_en && in_gap) begin
        low_run++;
      end
      if (!cfg_busy) in_gap = 1'b0;
      if (ad9833_wr_en && prev_en && ad9833_data !== prev_data) unstable++;
      if (cfg_done) done_cnt++;
      if (cfg_err) err_cnt++;
      if (cfg_done && cfg_err) both_cnt++;
      prev_en = ad9833_wr_en;
      prev_data = ad9833_data;
    end
  end

  task automatic start_cfg(input logic [27:0] f, input logic [11:0] p, input logic [1:0] w);
    @(negedge clk);
    freq_word  = f;
    phase_word = p;
    wave_sel   = w;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (cfg_done) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ad9833_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", ad9833_data); end
    checks++; if (ad9833_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", ad9833_wr_en); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", cfg_busy); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", cfg_done); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ad9833_wr_en !== 1'b0 || cfg_busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got wr_en=%b busy=%b expected 0 0", ad9833_wr_en, cfg_busy); end
  endtask

  task automatic test_nominal();
    logic [15:0] exp_w[5] = '{16'h2100, 16'h570A, 16'h428F, 16'hC400, 16'h2000};
    int bw = words.size(), bg = gaps.size();
    int bwin = win_cnt, bd = done_cnt, be = err_cnt, bu = unstable;
    logic [15:0] got;
    bit ok;
    start_cfg(28'h0A3D70A, 12'h400, 2'd0);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL nominal_done_seen: got timeout expected cfg_done within %0d cycles", BOUND); end
    checks++; if (win_cnt - bwin !== 5) begin errors++; $display("FAIL nominal_windows: got %0d expected 5", win_cnt - bwin); end
    for (int i = 0; i < 5; i++) begin
      got = (bw + i < words.size()) ? words[bw + i] : 16'hxxxx;
      checks++; if (got !== exp_w[i]) begin errors++; $display("FAIL nominal_word%0d: got %h expected %h", i, got, exp_w[i]); end
    end
    checks++; if (done_cnt - bd !== 1) begin errors++; $display("FAIL nominal_done_count: got %0d expected 1", done_cnt - bd); end
    checks++; if (err_cnt - be !== 0) begin errors++; $display("FAIL nominal_err_count: got %0d expected 0", err_cnt - be); end
    checks++; if (unstable - bu !== 0) begin errors++; $display("FAIL nominal_data_stable: got %0d changes expected 0", unstable - bu); end
    checks++; if (gaps.size() - bg !== 4) begin errors++; $display("FAIL nominal_gap_count: got %0d expected 4", gaps.size() - bg); end
    for (int i = bg; i < gaps.size(); i++) begin
      checks++; if (gaps[i] !== GAP) begin errors++; $display("FAIL nominal_gap%0d: got %0d expected %0d", i - bg, gaps[i], GAP); end
    end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_end: got %b expected 0", cfg_busy); end
  endtask

  task automatic test_wave_sel();
    bit ok;
    start_cfg(28'h0000001, 12'h000, 2'd2);
    wait_done(ok);
    checks++; if (!ok || words[words.size() - 1] !== 16'h2028) begin errors++; $display("FAIL wave_sel2: got %h done=%b expected 2028", words[words.size() - 1], ok); end
    start_cfg(28'h0000001, 12'h000, 2'd3);
    wait_done(ok);
    checks++; if (!ok || words[words.size() - 1] !== 16'h2020) begin errors++; $display("FAIL wave_sel3: got %h done=%b expected 2020", words[words.size() - 1], ok); end
  endtask

  task automatic test_timeout();
    int bwin = win_cnt, bd = done_cnt, be = err_cnt;
    int rise_c = -1, err_c = -1;
    logic en_at_err = 1'bx;
    ser_en = 1'b0;
    start_cfg(28'h0123456, 12'h321, 2'd1);
    for (int i = 0; i < 10 && rise_c < 0; i++) begin
      if (ad9833_wr_en) rise_c = cyc;
      else @(negedge clk);
    end
    for (int i = 0; i < 200 && err_c < 0; i++) begin
      @(negedge clk);
      if (cfg_err) begin
        err_c = cyc;
        en_at_err = ad9833_wr_en;
      end
    end
    @(negedge clk);
    checks++; if (err_c < 0 || rise_c < 0 || err_c - rise_c !== TMO) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", err_c - rise_c, TMO); end
    checks++; if (en_at_err !== 1'b0) begin errors++; $display("FAIL timeout_wr_en: got %b expected 0", en_at_err); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", cfg_busy); end
    repeat (100) @(negedge clk);
    checks++; if (win_cnt - bwin !== 1) begin errors++; $display("FAIL timeout_windows: got %0d expected 1", win_cnt - bwin); end
    checks++; if (done_cnt - bd !== 0) begin errors++; $display("FAIL timeout_no_done: got %0d expected 0", done_cnt - bd); end
    checks++; if (err_cnt - be !== 1) begin errors++; $display("FAIL timeout_err_count: got %0d expected 1", err_cnt - be); end
    ser_en = 1'b1;
  endtask

  task automatic test_busy_reject();
    logic [15:0] exp_w[5] = '{16'h2100, 16'h570A, 16'h428F, 16'hC400, 16'h2000};
    int bw = words.size(), bwin = win_cnt, bd = done_cnt;
    logic [15:0] got;
    bit ok;
    start_cfg(28'h0A3D70A, 12'h400, 2'd0);
    for (int i = 0; i < BOUND && words.size() < bw + 3; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    start_cfg(28'hFEDCBA9, 12'hABC, 2'd2);
    wait_done(ok);
    repeat (20) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL busy_done_seen: got timeout expected cfg_done"); end
    checks++; if (win_cnt - bwin !== 5) begin errors++; $display("FAIL busy_windows: got %0d expected 5", win_cnt - bwin); end
    checks++; if (done_cnt - bd !== 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", done_cnt - bd); end
    for (int i = 1; i < 5; i++) begin
      got = (bw + i < words.size()) ? words[bw + i] : 16'hxxxx;
      checks++; if (got !== exp_w[i]) begin errors++; $display("FAIL busy_word%0d: got %h expected %h", i, got, exp_w[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int bw = words.size(), bwin = win_cnt, bd = done_cnt;
    logic [15:0] got;
    bit ok;
    start_cfg(28'h0A3D70A, 12'h400, 2'd0);
    for (int i = 0; i < BOUND && words.size() < bw + 4; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ad9833_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en: got %b expected 0", ad9833_wr_en); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", cfg_busy); end
    checks++; if (ad9833_data !== 16'h0000) begin errors++; $display("FAIL rstmid_data: got %h expected 0000", ad9833_data); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    checks++; if (win_cnt - bwin !== 4) begin errors++; $display("FAIL rstmid_no_words: got %0d windows expected 4", win_cnt - bwin); end
    checks++; if (done_cnt - bd !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt - bd); end
    start_cfg(28'h0000ABC, 12'h055, 2'd1);
    wait_done(ok);
    got = (bw + 4 < words.size()) ? words[bw + 4] : 16'hxxxx;
    checks++; if (got !== 16'h2100) begin errors++; $display("FAIL rstmid_restart_w0: got %h expected 2100", got); end
    got = (bw + 8 < words.size()) ? words[bw + 8] : 16'hxxxx;
    checks++; if (!ok || got !== 16'h2002) begin errors++; $display("FAIL rstmid_restart_w4: got %h done=%b expected 2002", got, ok); end
    checks++; if (win_cnt - bwin !== 9) begin errors++; $display("FAIL rstmid_restart_windows: got %0d expected 9", win_cnt - bwin); end
  endtask

  task automatic test_gap_spurious();
    logic [15:0] exp_w[5] = '{16'h2100, 16'h7FFF, 16'h7FFF, 16'hCFFF, 16'h2002};
    int bw = words.size(), bg = gaps.size(), bwin = win_cnt, bd = done_cnt;
    logic [15:0] got;
    bit ok;
    spur_mode = 1'b1;
    start_cfg(28'hFFFFFFF, 12'hFFF, 2'd1);
    wait_done(ok);
    spur_mode = 1'b0;
    checks++; if (!ok || done_cnt - bd !== 1) begin errors++; $display("FAIL spur_done: got %0d expected 1", done_cnt - bd); end
    checks++; if (win_cnt - bwin !== 5) begin errors++; $display("FAIL spur_windows: got %0d expected 5", win_cnt - bwin); end
    for (int i = 0; i < 5; i++) begin
      got = (bw + i < words.size()) ? words[bw + i] : 16'hxxxx;
      checks++; if (got !== exp_w[i]) begin errors++; $display("FAIL spur_word%0d: got %h expected %h", i, got, exp_w[i]); end
    end
    checks++; if (gaps.size() - bg !== 4) begin errors++; $display("FAIL spur_gap_count: got %0d expected 4", gaps.size() - bg); end
    for (int i = bg; i < gaps.size(); i++) begin
      checks++; if (gaps[i] !== GAP) begin errors++; $display("FAIL spur_gap%0d: got %0d expected %0d", i - bg, gaps[i], GAP); end
    end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_err_exclusive: got %0d overlaps expected 0", both_cnt); end
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_start  = 1'b0;
    freq_word  = '0;
    phase_word = '0;
    wave_sel   = '0;
    test_reset();
    test_nominal();
    test_wave_sel();
    test_timeout();
    test_busy_reject();
    test_reset_mid();
    test_gap_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
